inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_N, default 2, instructions per fetch beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries; power of 2, at least 2*FETCH_N.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all queued and incoming instructions.
REQ-006 SHALL have port in_valid  input  1  fetch beat present.
REQ-007 SHALL have port in_ready  output  1  queue can accept one beat.
REQ-008 SHALL have port in_pc  input  32  PC of lane 0; word aligned.
REQ-009 SHALL have port in_mask  input  FETCH_N  lane valid bits; contiguous from lane 0.
REQ-010 SHALL have port in_data  input  32*FETCH_N  lane i in bits [32i+31:32i].
REQ-011 SHALL have ports out_valid0 and out_valid1  output  1 each  head and head+1 valid.
REQ-012 SHALL have ports out_pc0 and out_pc1  output  32 each  PCs of head and head+1.
REQ-013 SHALL have ports out_inst0 and out_inst1  output  32 each  instructions at head and head+1.
REQ-014 SHALL have port out_pop  input  2  instructions consumed this cycle: 0, 1 or 2.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL be a circular FIFO with write and read pointers that wrap modulo DEPTH, and each entry SHALL hold {pc, inst}.
REQ-017 SHALL drive in_ready = (DEPTH - count >= FETCH_N), based on the registered count only; a same-cycle pop SHALL NOT raise in_ready.
REQ-018 SHALL, on in_valid & in_ready & !flush, write popcount(in_mask) entries in lane order, with lane i having pc = in_pc + 4*i.
REQ-019 SHALL treat in_mask = 0 with in_valid as a no-op beat: no write and no count change.
REQ-020 SHALL drive out_valid0 = (count >= 1) and out_valid1 = (count >= 2), sourced from registered entries; push-to-output latency is 1 cycle.
REQ-021 SHALL drive out_pc/out_inst to 0 whenever the matching out_valid is low.
REQ-022 SHALL remove min(out_pop, count) entries per cycle; out_pop = 3, or out_pop exceeding the number of valid outputs, SHALL be clamped and SHALL NOT corrupt state.
REQ-023 SHALL support simultaneous push and pop, with count_next = count + pushed - popped; a full queue (count = DEPTH) with pop = 2 and push of FETCH_N SHALL be impossible because in_ready is low.
REQ-024 SHALL give flush priority: pointers and count go to 0 next cycle, and a same-cycle push and pop are discarded.
REQ-025 SHALL preserve program order across pointer wrap-around.

Reset
REQ-026 SHALL, while rst is high, asynchronously clear the pointers and count to 0; out_valid0/1 SHALL then be 0, out_pc/out_inst SHALL be 0, and in_ready SHALL be 1.
REQ-027 SHALL NOT reset entry storage.
REQ-028 SHALL abandon all contents when rst is asserted mid-operation, and SHALL accept a new beat on the first clk edge after rst falls.

Configuration
REQ-029 SHALL, with macro IFQ_BYPASS_EN defined and count = 0, present accepted lanes 0 and 1 combinationally on out_*0/1 in the same cycle; only lanes not popped that cycle SHALL be written.
REQ-030 SHALL, without IFQ_BYPASS_EN, have no combinational path from in_* to out_*, and push-to-output latency SHALL be exactly 1 cycle.

Verification
REQ-031 SHALL verify reset: assert rst mid-stream with count = 5 -> the same cycle shows out_valid0 = 0, count = 0, in_ready = 1.
REQ-032 SHALL verify a basic push: FETCH_N = 2, push in_pc = 0xBFC00000, mask = 2'b11 -> next cycle out_pc0 = 0xBFC00000, out_pc1 = 0xBFC00004, count = 2.
REQ-033 SHALL verify a partial mask: push mask = 2'b01 at in_pc = 0x80000010 -> count = 1, out_valid1 = 0, out_pc0 = 0x80000010.
REQ-034 SHALL verify full and wrap: DEPTH = 8, push 4 beats -> in_ready = 0; pop 2 per cycle while pushing 6 more beats -> PCs emerge strictly increasing by 4, and no entry is lost.
REQ-035 SHALL verify flush: count = 6 with a simultaneous push and out_pop = 2 under flush -> next cycle count = 0 and out_valid0 = 0.
REQ-036 SHALL verify bypass: with IFQ_BYPASS_EN defined, an empty queue, push of 2 lanes and out_pop = 1 -> out_valid0/1 = 1 in the same cycle, and next cycle count = 1 holding the lane-1 PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch queue, FETCH_N-wide push, 2-wide peek/pop
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue #(
  parameter int FETCH_N = 2,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [FETCH_N-1:0]            in_mask,
  input  logic [32*FETCH_N-1:0]         in_data,
  output logic                          out_valid0,
  output logic                          out_valid1,
  output logic [31:0]                   out_pc0,
  output logic [31:0]                   out_pc1,
  output logic [31:0]                   out_inst0,
  output logic [31:0]                   out_inst1,
  input  logic [1:0]                    out_pop,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_N);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr1;
  logic [CW-1:0] count_q;

  logic          push_fire;
  logic [CW-1:0] push_n;
  logic [1:0]    avail;
  logic [1:0]    pop_req;
  logic [1:0]    pop_n;
  logic [1:0]    skip;

  assign count     = count_q;
  assign in_ready  = (count_q <= READY_MAX);
  assign push_fire = in_valid & in_ready & ~flush;
  assign rd_ptr1   = rd_ptr + AW'(1);
  assign pop_req   = (out_pop == 2'd3) ? 2'd2 : out_pop;
  assign pop_n     = (pop_req < avail) ? pop_req : avail;

  always_comb begin
    push_n = '0;
    if (push_fire) begin
      for (int i = 0; i < FETCH_N; i++) begin
        push_n = push_n + CW'(in_mask[i]);
      end
    end
  end

`ifdef IFQ_BYPASS_EN
  logic                     bypass;
  logic [FETCH_N+1:0]       mask_pad;
  logic [32*FETCH_N+63:0]   data_pad;

  assign bypass   = push_fire && (count_q == '0);
  assign mask_pad = {2'b00, in_mask};
  assign data_pad = {64'd0, in_data};
  // Lanes consumed straight off the input are never written to storage.
  assign skip     = bypass ? pop_n : 2'd0;

  always_comb begin
    if (bypass) begin
      avail = (push_n >= CW'(2)) ? 2'd2 : push_n[1:0];
    end else begin
      avail = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    end
  end

  always_comb begin
    out_valid0 = 1'b0;
    out_valid1 = 1'b0;
    out_pc0    = '0;
    out_pc1    = '0;
    out_inst0  = '0;
    out_inst1  = '0;
    if (bypass) begin
      out_valid0 = mask_pad[0];
      out_valid1 = mask_pad[1];
      if (mask_pad[0]) begin
        out_pc0   = in_pc;
        out_inst0 = data_pad[31:0];
      end
      if (mask_pad[1]) begin
        out_pc1   = in_pc + 32'd4;
        out_inst1 = data_pad[63:32];
      end
    end else begin
      out_valid0 = (count_q >= CW'(1));
      out_valid1 = (count_q >= CW'(2));
      if (out_valid0) begin
        out_pc0   = pc_mem[rd_ptr];
        out_inst0 = inst_mem[rd_ptr];
      end
      if (out_valid1) begin
        out_pc1   = pc_mem[rd_ptr1];
        out_inst1 = inst_mem[rd_ptr1];
      end
    end
  end
`else
  assign skip  = 2'd0;
  assign avail = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

  always_comb begin
    out_valid0 = (count_q >= CW'(1));
    out_valid1 = (count_q >= CW'(2));
    out_pc0    = '0;
    out_pc1    = '0;
    out_inst0  = '0;
    out_inst1  = '0;
    if (out_valid0) begin
      out_pc0   = pc_mem[rd_ptr];
      out_inst0 = inst_mem[rd_ptr];
    end
    if (out_valid1) begin
      out_pc1   = pc_mem[rd_ptr1];
      out_inst1 = inst_mem[rd_ptr1];
    end
  end
`endif

  // Entry storage is deliberately not reset; count alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_N; i++) begin
      if (push_fire && in_mask[i] && (i >= int'(skip))) begin
        pc_mem[wr_ptr + AW'(i) - AW'(skip)]   <= in_pc + 32'(4 * i);
        inst_mem[wr_ptr + AW'(i) - AW'(skip)] <= in_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_n) - AW'(skip);
      rd_ptr  <= rd_ptr + AW'(pop_n - skip);
      count_q <= count_q + push_n - CW'(pop_n);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [1:0]  in_mask;
  logic [63:0] in_data;
  logic        out_valid0;
  logic        out_valid1;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [1:0]  out_pop;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.FETCH_N(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_mask(in_mask), .in_data(in_data),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pop(out_pop), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic set_beat(input logic v, input logic [31:0] pc, input logic [1:0] m);
    in_valid = v;
    in_pc    = pc;
    in_mask  = m;
    in_data  = {inst_of(pc + 32'd4), inst_of(pc)};
  endtask

  int beat;
  int popped;
  int n;
  logic [31:0] exp_pc;

  initial begin
    rst = 1'b1; flush = 1'b0; out_pop = 2'd0;
    set_beat(1'b0, 32'd0, 2'b00);
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_pc0", out_pc0, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;

    // basic two-lane push
    set_beat(1'b1, 32'hBFC0_0000, 2'b11);
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    chk("basic_pc0", out_pc0, 32'hBFC0_0000);
    chk("basic_pc1", out_pc1, 32'hBFC0_0004);
    chk("basic_inst1", out_inst1, inst_of(32'hBFC0_0004));
    chk("basic_count", 32'(count), 32'd2);

    out_pop = 2'd2;
    tick();
    out_pop = 2'd0;
    chk("pop2_count", 32'(count), 32'd0);
    chk("pop2_pc0_zero", out_pc0, 32'd0);

    // partial mask
    set_beat(1'b1, 32'h8000_0010, 2'b01);
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    chk("part_count", 32'(count), 32'd1);
    chk("part_valid1", 32'(out_valid1), 32'd0);
    chk("part_pc0", out_pc0, 32'h8000_0010);
    chk("part_pc1_zero", out_pc1, 32'd0);

    // out_pop=3 with one entry clamps to one
    out_pop = 2'd3;
    tick();
    out_pop = 2'd0;
    chk("clamp_count", 32'(count), 32'd0);
    chk("clamp_valid0", 32'(out_valid0), 32'd0);

    // empty-mask beat is a no-op
    set_beat(1'b1, 32'h0000_4000, 2'b00);
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    chk("nomask_count", 32'(count), 32'd0);

    // fill, then drain two per cycle while pushing across the wrap point
    for (int k = 0; k < 4; k++) begin
      set_beat(1'b1, 32'h1000 + 32'(8 * k), 2'b11);
      tick();
    end
    set_beat(1'b0, 32'd0, 2'b00);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);

    beat = 4; popped = 0; exp_pc = 32'h1000;
    for (int cyc = 0; cyc < 60 && (beat < 10 || popped < 20); cyc++) begin
      set_beat(beat < 10, 32'h1000 + 32'(8 * beat), 2'b11);
      out_pop = 2'd2;
      #1;
      n = out_valid1 ? 2 : (out_valid0 ? 1 : 0);
      if (n >= 1) begin
        chk("wrap_pc0", out_pc0, exp_pc);
        chk("wrap_inst0", out_inst0, inst_of(exp_pc));
      end
      if (n == 2) chk("wrap_pc1", out_pc1, exp_pc + 32'd4);
      popped += n;
      exp_pc += 32'(4 * n);
      if (in_valid && in_ready) beat++;
      tick();
    end
    set_beat(1'b0, 32'd0, 2'b00);
    out_pop = 2'd0;
    chk("wrap_popped", 32'(popped), 32'd20);
    chk("wrap_beats", 32'(beat), 32'd10);
    chk("wrap_count", 32'(count), 32'd0);

    // flush beats a same-cycle push and pop
    for (int k = 0; k < 3; k++) begin
      set_beat(1'b1, 32'h5000 + 32'(8 * k), 2'b11);
      tick();
    end
    chk("preflush_count", 32'(count), 32'd6);
    set_beat(1'b1, 32'h6000, 2'b11);
    out_pop = 2'd2;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_pop = 2'd0;
    set_beat(1'b0, 32'd0, 2'b00);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid0", 32'(out_valid0), 32'd0);

    // asynchronous reset mid-stream
    set_beat(1'b1, 32'h7000, 2'b11);
    tick(); tick();
    set_beat(1'b1, 32'h7010, 2'b01);
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    chk("prerst_count", 32'(count), 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_valid0", 32'(out_valid0), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    set_beat(1'b1, 32'h2000, 2'b11);
    #2;
    rst = 1'b0;
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    chk("postrst_count", 32'(count), 32'd2);
    chk("postrst_pc0", out_pc0, 32'h2000);

`ifdef IFQ_BYPASS_EN
    out_pop = 2'd2;
    tick();
    out_pop = 2'd0;
    chk("byp_empty", 32'(count), 32'd0);
    set_beat(1'b1, 32'h3000, 2'b11);
    out_pop = 2'd1;
    #1;
    chk("byp_valid0", 32'(out_valid0), 32'd1);
    chk("byp_valid1", 32'(out_valid1), 32'd1);
    chk("byp_pc0", out_pc0, 32'h3000);
    tick();
    set_beat(1'b0, 32'd0, 2'b00);
    out_pop = 2'd0;
    chk("byp_count", 32'(count), 32'd1);
    chk("byp_next_pc0", out_pc0, 32'h3004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
